// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - dot-product sequencer streaming element pairs through a registered fp32 MAC
// Optional abort input enabled by defining MAC_DOT_SEQ_ABORT_EN.

module mac (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  output logic [31:0] o_ieee,
  output logic        o_ovf,
  output logic        o_unf
);
  // Fused a*b+c, round-to-nearest-even; subnormal inputs and results are flushed to zero.
  logic [7:0]         w_ea, w_eb, w_ec;
  logic               w_sp, w_sc, w_za, w_zb, w_zc, w_pz;
  logic               w_a_inf, w_b_inf, w_c_inf, w_nan;
  logic [47:0]        w_mp, w_x, w_y, w_big, w_small;
  logic signed [10:0] w_ex, w_ey, w_ebig, w_d, w_e;
  logic               w_sbig, w_eff_sub, w_found, w_inc;
  logic [51:0]        w_bf, w_sf0, w_sf, w_mask, w_sum, w_norm;
  logic [5:0]         w_lz;
  logic [23:0]        w_frac;
  logic [31:0]        w_res;
  logic               w_ovf, w_unf;

  assign w_ea    = i_a[30:23];
  assign w_eb    = i_b[30:23];
  assign w_ec    = i_c[30:23];
  assign w_sp    = i_a[31] ^ i_b[31];
  assign w_sc    = i_c[31];
  assign w_za    = (w_ea == 8'd0);
  assign w_zb    = (w_eb == 8'd0);
  assign w_zc    = (w_ec == 8'd0);
  assign w_pz    = w_za | w_zb;
  assign w_a_inf = (w_ea == 8'hFF) && (i_a[22:0] == 23'd0);
  assign w_b_inf = (w_eb == 8'hFF) && (i_b[22:0] == 23'd0);
  assign w_c_inf = (w_ec == 8'hFF) && (i_c[22:0] == 23'd0);
  assign w_nan   = ((w_ea == 8'hFF) && (i_a[22:0] != 23'd0)) ||
                   ((w_eb == 8'hFF) && (i_b[22:0] != 23'd0)) ||
                   ((w_ec == 8'hFF) && (i_c[22:0] != 23'd0)) ||
                   (w_a_inf && w_zb) || (w_b_inf && w_za) ||
                   ((w_a_inf || w_b_inf) && w_c_inf && (w_sp != w_sc));
  assign w_mp    = {24'd0, 1'b1, i_a[22:0]} * {24'd0, 1'b1, i_b[22:0]};
  assign w_y     = {1'b1, i_c[22:0], 24'd0};
  assign w_ey    = $signed({3'b000, w_ec}) - 11'sd1;

  // Both operands end up with their leading one at bit 47, so magnitude order is (exp, mantissa).
  always_comb begin
    if (w_mp[47]) begin
      w_x  = w_mp;
      w_ex = $signed({3'b000, w_ea}) + $signed({3'b000, w_eb}) - 11'sd127;
    end else begin
      w_x  = {w_mp[46:0], 1'b0};
      w_ex = $signed({3'b000, w_ea}) + $signed({3'b000, w_eb}) - 11'sd128;
    end
  end

  always_comb begin
    w_big     = w_x;
    w_small   = w_y;
    w_ebig    = w_ex;
    w_d       = w_ex - w_ey;
    w_sbig    = w_sp;
    w_eff_sub = w_sp ^ w_sc;
    if (w_pz) begin
      w_big   = w_y;
      w_small = '0;
      w_ebig  = w_ey;
      w_d     = '0;
      w_sbig  = w_sc;
    end else if (w_zc) begin
      w_small = '0;
      w_d     = '0;
    end else if ((w_ey > w_ex) || ((w_ey == w_ex) && (w_y > w_x))) begin
      w_big   = w_y;
      w_small = w_x;
      w_ebig  = w_ey;
      w_d     = w_ey - w_ex;
      w_sbig  = w_sc;
    end
  end

  always_comb begin
    w_bf   = {1'b0, w_big, 3'b000};
    w_sf0  = {1'b0, w_small, 3'b000};
    w_mask = '0;
    if (w_d >= 11'sd52) begin
      w_sf = {51'd0, |w_small};
    end else begin
      w_mask = (52'd1 << w_d[5:0]) - 52'd1;
      w_sf   = (w_sf0 >> w_d[5:0]) | {51'd0, |(w_sf0 & w_mask)};
    end
    w_sum = w_eff_sub ? (w_bf - w_sf) : (w_bf + w_sf);
  end

  always_comb begin
    w_lz    = 6'd0;
    w_found = 1'b0;
    for (int i = 51; i >= 0; i--) begin
      if (!w_found && w_sum[i]) begin
        w_lz    = 6'(51 - i);
        w_found = 1'b1;
      end
    end
    w_norm = w_sum << w_lz;
    w_inc  = w_norm[27] & ((|w_norm[26:0]) | w_norm[28]);
    w_frac = {1'b0, w_norm[50:28]} + {23'd0, w_inc};
    w_e    = w_ebig + 11'sd2 - $signed({5'b00000, w_lz}) + $signed({10'd0, w_frac[23]});
  end

  always_comb begin
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_res = {w_sbig, w_e[7:0], w_frac[22:0]};
    if (w_nan) begin
      w_res = 32'h7FC0_0000;
    end else if (w_a_inf || w_b_inf) begin
      w_res = {w_sp, 8'hFF, 23'd0};
    end else if (w_c_inf) begin
      w_res = {w_sc, 8'hFF, 23'd0};
    end else if (w_pz && w_zc) begin
      w_res = {w_sp & w_sc, 31'd0};
    end else if (!w_norm[51]) begin
      w_res = 32'd0;
    end else if (w_e >= 11'sd255) begin
      w_res = {w_sbig, 8'hFF, 23'd0};
      w_ovf = 1'b1;
    end else if (w_e <= 11'sd0) begin
      w_res = {w_sbig, 31'd0};
      w_unf = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ieee <= 32'd0;
      o_ovf  <= 1'b0;
      o_unf  <= 1'b0;
    end else begin
      o_ieee <= w_res;
      o_ovf  <= w_ovf;
      o_unf  <= w_unf;
    end
  end
endmodule

module mac_dot_seq #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MAC_DOT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [LEN_W-1:0] start_len,
  input  logic [31:0]      start_init,
  input  logic             elem_valid,
  output logic             elem_ready,
  input  logic [31:0]      elem_a,
  input  logic [31:0]      elem_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_ovf,
  output logic             res_unf,
  output logic             busy
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_remaining;
  logic [31:0]      r_init, r_res_data;
  logic             r_first, r_ovf, r_unf, r_res_valid, r_res_ovf, r_res_unf;
  logic             w_active, w_abort, w_issue;
  logic [31:0]      w_mac_a, w_mac_b, w_mac_c, w_mac_ieee;
  logic             w_mac_ovf, w_mac_unf;

  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
`ifdef MAC_DOT_SEQ_ABORT_EN
  assign w_abort  = abort && w_active;
`else
  assign w_abort  = 1'b0;
`endif
  assign w_issue  = (r_state == S_RUN) && elem_valid && !w_abort;

  // Idle cycles inside a job multiply 0*0 and add the running sum back, so it is held in the MAC.
  assign w_mac_a = w_issue ? elem_a : 32'd0;
  assign w_mac_b = w_issue ? elem_b : 32'd0;
  assign w_mac_c = !w_active ? 32'd0 : ((w_issue && r_first) ? r_init : w_mac_ieee);

  mac u_mac (
    .i_clk  (clk),
    .i_rst  (~rst_n),
    .i_a    (w_mac_a),
    .i_b    (w_mac_b),
    .i_c    (w_mac_c),
    .o_ieee (w_mac_ieee),
    .o_ovf  (w_mac_ovf),
    .o_unf  (w_mac_unf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_init      <= 32'd0;
      r_first     <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= 32'd0;
      r_res_ovf   <= 1'b0;
      r_res_unf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_remaining <= start_len;
            r_init      <= start_init;
            r_first     <= 1'b1;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_res_ovf   <= 1'b0;
            r_res_unf   <= 1'b0;
            if (start_len == '0) begin
              r_res_data <= start_init;
              r_state    <= S_DONE;
            end else begin
              r_state    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_ovf <= r_ovf | w_mac_ovf;
            r_unf <= r_unf | w_mac_unf;
            if (w_issue) begin
              r_first     <= 1'b0;
              r_remaining <= r_remaining - LEN_W'(1);
              if (r_remaining == LEN_W'(1)) r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_abort) begin
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_ovf      <= r_ovf | w_mac_ovf;
            r_unf      <= r_unf | w_mac_unf;
            r_res_data <= w_mac_ieee;
            r_res_ovf  <= r_ovf | w_mac_ovf;
            r_res_unf  <= r_unf | w_mac_unf;
            r_state    <= S_DONE;
          end
        end
        default: begin
          // res_valid rises one cycle into DONE, which gives the fixed result latency.
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_res_valid <= 1'b1;
          end
        end
      endcase
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign elem_ready  = (r_state == S_RUN);
  assign busy        = (r_state != S_IDLE);
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_ovf     = r_res_ovf;
  assign res_unf     = r_res_unf;
endmodule

// File: tb/tb_mac_dot_seq.sv
// tb/tb_mac_dot_seq.sv - scoreboard bench for mac_dot_seq
module tb_mac_dot_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
`ifdef MAC_DOT_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] start_len = '0;
  logic [31:0] start_init = '0;
  logic        elem_valid = 1'b0;
  logic        elem_ready;
  logic [31:0] elem_a = '0;
  logic [31:0] elem_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_ovf, res_unf, busy;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] va [0:15];
  logic [31:0] vb [0:15];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mac_dot_seq #(.LEN_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef MAC_DOT_SEQ_ABORT_EN
    .abort       (abort),
`endif
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_len   (start_len),
    .start_init  (start_init),
    .elem_valid  (elem_valid),
    .elem_ready  (elem_ready),
    .elem_a      (elem_a),
    .elem_b      (elem_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_ovf     (res_ovf),
    .res_unf     (res_unf),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic o, input logic u);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    e.unf  = u;
    return e;
  endfunction

  function automatic logic [31:0] int_to_f32(input int v);
    int m;
    int p;
    if (v == 0) return 32'd0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int k = 0; k < 24; k++) if (m >= (1 << k)) p = k;
    return {(v < 0), 8'(127 + p), 23'((m << (23 - p)) & 32'h007F_FFFF)};
  endfunction

  task automatic start_job(input logic [15:0] len, input logic [31:0] init);
    int n;
    n = 0;
    while (!start_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_ready", start_ready, 1);
    start_valid = 1'b1;
    start_len   = len;
    start_init  = init;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic send_elems(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      elem_valid = 1'b1;
      elem_a     = va[i];
      elem_b     = vb[i];
      check("elem_ready", elem_ready, 1);
      @(negedge clk);
      elem_valid = 1'b0;
      if (i < n - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic get_result(input int exp_lat, input int hold);
    int   n;
    logic saw_er;
    exp_t e;
    n      = 0;
    saw_er = 1'b0;
    while (!res_valid && n < 50) begin
      saw_er |= elem_ready;
      @(negedge clk);
      n++;
    end
    check("latency", n, exp_lat);
    check("no_elem_ready", saw_er, 0);
    check("sb_nonempty", sb_q.size() > 0, 1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : mk(32'd0, 1'b0, 1'b0);
    repeat (hold) begin
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, e.data);
      check("hold_start_ready", start_ready, 0);
      @(negedge clk);
    end
    check("res_data", res_data, e.data);
    check("res_ovf", res_ovf, e.ovf);
    check("res_unf", res_unf, e.unf);
    check("busy_done", busy, 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_drop", res_valid, 0);
    check("start_ready_back", start_ready, 1);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int len;
    int acc;
    int x;
    int y;
    logic [31:0] init;

    repeat (2) @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_ovf", res_ovf, 0);
    check("rst_res_unf", res_unf, 0);
    check("rst_busy", busy, 0);
    check("rst_start_ready", start_ready, 1);
    check("rst_elem_ready", elem_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    va[0] = 32'h3F80_0000; vb[0] = 32'h4040_0000;
    va[1] = 32'h4000_0000; vb[1] = 32'h4080_0000;
    sb_q.push_back(mk(32'h4130_0000, 1'b0, 1'b0));
    start_job(16'd2, 32'd0);
    send_elems(2, 0);
    get_result(2, 0);

    sb_q.push_back(mk(32'h4140_0000, 1'b0, 1'b0));
    start_job(16'd2, 32'h3F80_0000);
    send_elems(2, 3);
    get_result(2, 0);

    va[0] = 32'h7F7F_FFFF; vb[0] = 32'h4000_0000;
    sb_q.push_back(mk(32'h7F80_0000, 1'b1, 1'b0));
    start_job(16'd1, 32'd0);
    send_elems(1, 0);
    get_result(2, 0);

    va[0] = 32'h3F80_0000; vb[0] = 32'h4040_0000;
    sb_q.push_back(mk(32'h4130_0000, 1'b0, 1'b0));
    start_job(16'd2, 32'd0);
    send_elems(2, 0);
    get_result(2, 5);

    sb_q.push_back(mk(32'h40A0_0000, 1'b0, 1'b0));
    start_job(16'd0, 32'h40A0_0000);
    get_result(1, 0);

    va[0] = 32'h4000_0000; vb[0] = 32'h4000_0000;
    start_job(16'd3, 32'd0);
    send_elems(1, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_data", res_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_start_ready", start_ready, 1);
    check("mid_rst_elem_ready", elem_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    va[0] = 32'h3F80_0000; vb[0] = 32'h3F80_0000;
    sb_q.push_back(mk(32'h3F80_0000, 1'b0, 1'b0));
    start_job(16'd1, 32'd0);
    send_elems(1, 0);
    get_result(2, 0);

    for (int j = 0; j < 6; j++) begin
      len  = 1 + int'($urandom_range(5, 0));
      acc  = int'($urandom_range(16, 0)) - 8;
      init = int_to_f32(acc);
      for (int i = 0; i < len; i++) begin
        x = int'($urandom_range(16, 0)) - 8;
        y = int'($urandom_range(16, 0)) - 8;
        va[i] = int_to_f32(x);
        vb[i] = int_to_f32(y);
        acc += x * y;
      end
      sb_q.push_back(mk(int_to_f32(acc), 1'b0, 1'b0));
      start_job(16'(len), init);
      send_elems(len, int'($urandom_range(1, 0)));
      get_result(2, 0);
    end

`ifdef MAC_DOT_SEQ_ABORT_EN
    va[0] = 32'h3F80_0000; vb[0] = 32'h3F80_0000;
    start_job(16'd4, 32'd0);
    send_elems(1, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_start_ready", start_ready, 1);
    repeat (3) begin
      check("abort_no_valid", res_valid, 0);
      @(negedge clk);
    end
    va[0] = 32'h3F80_0000; vb[0] = 32'h4040_0000;
    va[1] = 32'h4000_0000; vb[1] = 32'h4080_0000;
    sb_q.push_back(mk(32'h4130_0000, 1'b0, 1'b0));
    start_job(16'd2, 32'd0);
    send_elems(2, 0);
    get_result(2, 0);
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
